cpu_controller_p: RTL and testbench
===================================

Name: cpu_controller_p

Overview:
- Parametrised multi-cycle control unit for the simple CPU datapath.
- Fetches an instruction word when memory signals ready and latches it into an internal IR. Decodes the opcode and sequences register-enable and tristate-select one-hot vectors, ALU op, PC increment and branch.
- Successor to the fixed 10-register controller. Adds a configurable register count, an ALU-op output, a zero flag with conditional branch, a memory-ready wait, halt, and illegal-index detection.

Parameters:
- INST_W, 23, instruction width; opcode is [INST_W-1 -: 3].
- NREG, 8, number of GPRs R0..NREG-1; requires NREG+2 <= 2**REG_IDX_W.
- REG_IDX_W, 4, width of the Rx field [INST_W-4 -: REG_IDX_W] and of the Ry field directly below it.
- OH_W, NREG+2, one-hot width. Index NREG = A register (r_en) / G register (tri); index NREG+1 = G register (r_en) / DIN bus (tri).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  leave IDLE and begin fetching.
- code  in  INST_W  instruction word from memory; valid when mem_ready=1.
- mem_ready  in  1  instruction-fetch handshake.
- alu_zero  in  1  ALU result==0; sampled in EXEC2.
- r_en_OH  out  OH_W  register write enables, one-hot or all-zero.
- tri_controller_OH  out  OH_W  bus driver select, one-hot or all-zero.
- alu_op  out  2  00 add, 01 sub, 10 and; meaningful only in EXEC2.
- inc_pc  out  1  PC increment pulse.
- branch  out  1  load PC from DIN bus.
- done  out  1  one-cycle pulse on an instruction's final cycle.
- illegal  out  1  one-cycle pulse when an instruction is dropped.
- halted  out  1  high while in HALT.

Behaviour:
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,DIN; 010 add; 011 sub; 100 and; 101 bz; 110 br; 111 halt.
- States: IDLE, FETCH, DECODE, EXEC1, EXEC2, EXEC3, HALT.
- Outputs are combinational from (state, IR, Z). They carry no extra register stage.
- Unlisted outputs are 0 in every state.
- Reset: synchronous. Next edge forces state=IDLE, IR=0, Z=0. All outputs read 0 in IDLE. Applies mid-instruction, aborting it with no further enables.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH:
  - mem_ready=0: stay, inc_pc=0.
  - mem_ready=1: inc_pc=1 that cycle, IR<=code, -> DECODE.
- DECODE: one cycle, no enables.
  - Rx>=NREG, or Ry>=NREG for mv/add/sub/and: illegal=1, -> FETCH.
  - halt -> HALT.
  - Otherwise -> EXEC1.
- mv: EXEC1 tri=Ry, r_en=Rx, done=1 -> FETCH.
- mvi: EXEC1 tri=NREG+1, r_en=Rx, done=1 -> FETCH.
- add/sub/and:
  - EXEC1: tri=Rx, r_en=NREG (A).
  - EXEC2: tri=Ry, r_en=NREG+1 (G), alu_op set, Z<=alu_zero.
  - EXEC3: tri=NREG (G), r_en=Rx, done=1 -> FETCH.
- bz: EXEC1 done=1 -> FETCH.
  - Z=1: tri=NREG+1, branch=1.
  - Z=0: no enables.
- br: EXEC1 tri=NREG+1, branch=1, done=1 -> FETCH.
- HALT: halted=1; stays until rst. start is ignored.
- start is only examined in IDLE. The controller runs continuously once started.
- Z persists across instructions and changes only in EXEC2 or on reset.
- Latency in cycles, from mem_ready high to done: mv, mvi, bz, br = 3; ALU ops = 5.
- inc_pc and branch are never high in the same cycle.
- Never more than one bit is set in either one-hot vector.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode constants.
  - state enum, 3-bit.
  - ALU op codes.
  - index helper functions IDX_A/IDX_G_EN/IDX_G_TRI/IDX_DIN in terms of NREG.
- Sub-module binary_to_onehot_p, parametrised (IN_W, OUT_W, valid input). Output is all-zero when valid=0 or the input is >= OUT_W. Instantiated twice.

Test Plan:
- Reset/idle: assert rst during EXEC2 of an add -> next cycle state IDLE, r_en_OH=0, tri_controller_OH=0, halted=0; start=0 for 5 cycles -> still idle.
- mv with wait: start=1, mem_ready=0 for 3 cycles then 1, code=000_0011_0101 (mv R3,R5) -> exactly one inc_pc pulse; then EXEC1 tri_controller_OH=0x020, r_en_OH=0x008, done=1.
- add with zero flag: add R1,R2, alu_zero=1 in EXEC2 -> the three cycles show r_en 0x100/0x200/0x002, tri 0x002/0x004/0x100, alu_op=00; a following bz asserts branch=1, tri=0x200.
- bz not taken: sub with alu_zero=0, then bz -> branch=0, all enables 0, done=1.
- Illegal index: mv R9,R0 with NREG=8 -> illegal=1 in DECODE, no r_en pulses, next FETCH.
- Halt: opcode 111 -> halted=1 held for 20 cycles with start toggling; rst -> IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multi-cycle CPU controller: opcodes, FSM states, ALU op
// codes and the positions of the A/G/DIN entries in the one-hot vectors.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_BZ   = 3'b101,
    OP_BR   = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_EXEC3, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_e;

  // Entries past the GPRs: A and G share index NREG, G and DIN share NREG+1.
  function automatic int IDX_A(input int nreg);
    return nreg;
  endfunction

  function automatic int IDX_G_EN(input int nreg);
    return nreg + 1;
  endfunction

  function automatic int IDX_G_TRI(input int nreg);
    return nreg;
  endfunction

  function automatic int IDX_DIN(input int nreg);
    return nreg + 1;
  endfunction

  function automatic alu_op_e alu_code(input opcode_e op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/binary_to_onehot_p.sv
// Binary index to one-hot decoder; all-zero when not valid or index out of range.
module binary_to_onehot_p #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 10
) (
  input  logic [IN_W-1:0]  bin_i,
  input  logic             valid_i,
  output logic [OUT_W-1:0] oh_o
);

  // An index >= OUT_W matches no position, so it decodes to all-zero.
  always_comb begin
    for (int i = 0; i < OUT_W; i++) begin
      oh_o[i] = valid_i && (bin_i == IN_W'(i));
    end
  end

endmodule

// File: rtl/cpu_controller_p.sv
// Multi-cycle control unit: latches an instruction on mem_ready, decodes it and
// sequences one-hot register enables / bus selects, ALU op, PC increment and branch.
module cpu_controller_p
  import cpu_ctrl_pkg::*;
#(
  parameter int INST_W    = 23,
  parameter int NREG      = 8,
  parameter int REG_IDX_W = 4,
  parameter int OH_W      = NREG + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [INST_W-1:0] code,
  input  logic              mem_ready,
  input  logic              alu_zero,
  output logic [OH_W-1:0]   r_en_OH,
  output logic [OH_W-1:0]   tri_controller_OH,
  output logic [1:0]        alu_op,
  output logic              inc_pc,
  output logic              branch,
  output logic              done,
  output logic              illegal,
  output logic              halted
);

  typedef logic [REG_IDX_W-1:0] idx_t;

  localparam idx_t NREG_I    = idx_t'(NREG);
  localparam idx_t A_EN_I    = idx_t'(IDX_A(NREG));
  localparam idx_t G_EN_I    = idx_t'(IDX_G_EN(NREG));
  localparam idx_t G_TRI_I   = idx_t'(IDX_G_TRI(NREG));
  localparam idx_t DIN_TRI_I = idx_t'(IDX_DIN(NREG));

  state_e            state_q, state_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic              z_q, z_d;

  opcode_e op;
  idx_t    rx, ry;
  logic    alu_inst, uses_ry, bad_idx;

  assign op = opcode_e'(ir_q[INST_W-1 -: 3]);
  assign rx = ir_q[INST_W-4 -: REG_IDX_W];
  assign ry = ir_q[INST_W-4-REG_IDX_W -: REG_IDX_W];

  assign alu_inst = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  assign uses_ry  = alu_inst || (op == OP_MV);
  assign bad_idx  = (rx >= NREG_I) || (uses_ry && (ry >= NREG_I));

  // The low IR bits below the Ry field carry no control meaning.
  logic unused_ir;
  assign unused_ir = ^ir_q;

  idx_t r_idx, t_idx;
  logic r_vld, t_vld;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    ir_d     = ir_q;
    z_d      = z_q;
    r_idx    = '0;
    r_vld    = 1'b0;
    t_idx    = '0;
    t_vld    = 1'b0;
    alu_op   = ALU_ADD;
    inc_pc   = 1'b0;
    branch   = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;

      S_FETCH: if (mem_ready) begin
        inc_pc  = 1'b1;
        ir_d    = code;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (bad_idx) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC1;
        end
      end

      S_EXEC1: begin
        state_d = alu_inst ? S_EXEC2 : S_FETCH;
        done    = !alu_inst;
        case (op)
          OP_MV:  begin t_idx = ry; t_vld = 1'b1; r_idx = rx; r_vld = 1'b1; end
          OP_MVI: begin t_idx = DIN_TRI_I; t_vld = 1'b1; r_idx = rx; r_vld = 1'b1; end
          OP_ADD, OP_SUB, OP_AND: begin
            t_idx = rx; t_vld = 1'b1; r_idx = A_EN_I; r_vld = 1'b1;
          end
          OP_BZ: if (z_q) begin
            t_idx = DIN_TRI_I; t_vld = 1'b1; branch = 1'b1;
          end
          OP_BR:  begin t_idx = DIN_TRI_I; t_vld = 1'b1; branch = 1'b1; end
          default: ;
        endcase
      end

      S_EXEC2: begin
        t_idx   = ry;
        t_vld   = 1'b1;
        r_idx   = G_EN_I;
        r_vld   = 1'b1;
        alu_op  = alu_code(op);
        z_d     = alu_zero;
        state_d = S_EXEC3;
      end

      S_EXEC3: begin
        t_idx   = G_TRI_I;
        t_vld   = 1'b1;
        r_idx   = rx;
        r_vld   = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  binary_to_onehot_p #(.IN_W(REG_IDX_W), .OUT_W(OH_W)) u_r_en_dec (
    .bin_i  (r_idx),
    .valid_i(r_vld),
    .oh_o   (r_en_OH)
  );

  binary_to_onehot_p #(.IN_W(REG_IDX_W), .OUT_W(OH_W)) u_tri_dec (
    .bin_i  (t_idx),
    .valid_i(t_vld),
    .oh_o   (tri_controller_OH)
  );

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

endmodule

// File: tb/tb_cpu_controller_p.sv
// Self-checking bench for cpu_controller_p: each instruction is expanded into
// its expected per-cycle output trace and compared every cycle.
module tb_cpu_controller_p;

  localparam int INST_W    = 23;
  localparam int NREG      = 8;
  localparam int REG_IDX_W = 4;
  localparam int OH_W      = NREG + 2;

  localparam int T_MV = 0, T_MVI = 1, T_ADD = 2, T_SUB = 3;
  localparam int T_AND = 4, T_BZ = 5, T_BR = 6, T_HALT = 7;

  typedef struct packed {
    logic [OH_W-1:0] r_en;
    logic [OH_W-1:0] tri_oh;
    logic [1:0]      alu_op;
    logic            inc_pc;
    logic            branch;
    logic            done;
    logic            illegal;
    logic            halted;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [INST_W-1:0] code;
  logic              mem_ready;
  logic              alu_zero;
  logic [OH_W-1:0]   r_en_OH;
  logic [OH_W-1:0]   tri_controller_OH;
  logic [1:0]        alu_op;
  logic              inc_pc, branch, done, illegal, halted;

  int checks = 0;
  int errors = 0;
  logic model_z = 1'b0;

  cpu_controller_p #(
    .INST_W(INST_W), .NREG(NREG), .REG_IDX_W(REG_IDX_W), .OH_W(OH_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .code             (code),
    .mem_ready        (mem_ready),
    .alu_zero         (alu_zero),
    .r_en_OH          (r_en_OH),
    .tri_controller_OH(tri_controller_OH),
    .alu_op           (alu_op),
    .inc_pc           (inc_pc),
    .branch           (branch),
    .done             (done),
    .illegal          (illegal),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [OH_W-1:0] oh(input int i);
    logic [OH_W-1:0] v;
    v = '0;
    if (i >= 0 && i < OH_W) v[i] = 1'b1;
    return v;
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.r_en    = r_en_OH;
    o.tri_oh  = tri_controller_OH;
    o.alu_op  = alu_op;
    o.inc_pc  = inc_pc;
    o.branch  = branch;
    o.done    = done;
    o.illegal = illegal;
    o.halted  = halted;
    return o;
  endfunction

  function automatic logic [INST_W-1:0] enc(input int op, input int rx, input int ry);
    logic [INST_W-1:0] w;
    w = INST_W'($urandom);
    w[INST_W-1 -: 3]                   = op[2:0];
    w[INST_W-4 -: REG_IDX_W]           = rx[REG_IDX_W-1:0];
    w[INST_W-4-REG_IDX_W -: REG_IDX_W] = ry[REG_IDX_W-1:0];
    return w;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed r_en=%h tri=%h alu=%b inc=%b br=%b done=%b ill=%b halt=%b expected r_en=%h tri=%h alu=%b inc=%b br=%b done=%b ill=%b halt=%b",
             tag, got.r_en, got.tri_oh, got.alu_op, got.inc_pc, got.branch, got.done,
             got.illegal, got.halted, exp.r_en, exp.tri_oh, exp.alu_op, exp.inc_pc,
             exp.branch, exp.done, exp.illegal, exp.halted);
    end
  endtask

  // Inputs are already applied; compare mid-cycle, then advance one clock.
  task automatic step(input string tag, input obs_t exp);
    @(negedge clk);
    check(tag, cur_obs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step("idle_start", '0);
    start = 1'b0;
  endtask

  // Drives one instruction from FETCH and checks its whole expected trace.
  task automatic run_instr(input int op, input int rx, input int ry, input int waits,
                           input logic az, input bit abort_exec2);
    obs_t e;
    bit   bad;
    for (int w = 0; w < waits; w++) begin
      mem_ready = 1'b0;
      code      = INST_W'($urandom);
      step("fetch_wait", '0);
    end
    mem_ready = 1'b1;
    code      = enc(op, rx, ry);
    e = '0; e.inc_pc = 1'b1;
    step("fetch", e);
    mem_ready = 1'b0;
    code      = INST_W'($urandom);

    bad = (rx >= NREG) ||
          ((op == T_MV || op == T_ADD || op == T_SUB || op == T_AND) && ry >= NREG);
    e = '0; e.illegal = bad;
    step("decode", e);
    if (bad || op == T_HALT) return;

    e = '0;
    case (op)
      T_MV:  begin e.tri_oh = oh(ry); e.r_en = oh(rx); e.done = 1'b1; end
      T_MVI: begin e.tri_oh = oh(NREG + 1); e.r_en = oh(rx); e.done = 1'b1; end
      T_BZ:  begin
        e.done = 1'b1;
        if (model_z) begin e.tri_oh = oh(NREG + 1); e.branch = 1'b1; end
      end
      T_BR:  begin e.tri_oh = oh(NREG + 1); e.branch = 1'b1; e.done = 1'b1; end
      default: begin e.tri_oh = oh(rx); e.r_en = oh(NREG); end
    endcase
    step("exec1", e);
    if (!(op == T_ADD || op == T_SUB || op == T_AND)) return;

    alu_zero = az;
    if (abort_exec2) rst = 1'b1;
    e = '0;
    e.tri_oh = oh(ry);
    e.r_en   = oh(NREG + 1);
    e.alu_op = (op == T_SUB) ? 2'b01 : (op == T_AND) ? 2'b10 : 2'b00;
    step("exec2", e);
    alu_zero = 1'($urandom);
    if (abort_exec2) begin
      rst     = 1'b0;
      model_z = 1'b0;
      return;
    end
    model_z = az;

    e = '0; e.tri_oh = oh(NREG); e.r_en = oh(rx); e.done = 1'b1;
    step("exec3", e);
  endtask

  initial begin
    obs_t e;
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; code = '0; alu_zero = 1'b0;
    @(posedge clk);
    #1;
    step("reset", '0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("idle_hold", '0);

    do_start();
    run_instr(T_MV, 3, 5, 3, 1'b0, 1'b0);
    run_instr(T_ADD, 1, 2, 0, 1'b1, 1'b0);
    run_instr(T_BZ, 0, 0, 1, 1'b0, 1'b0);
    run_instr(T_SUB, 4, 6, 2, 1'b0, 1'b0);
    run_instr(T_BZ, 2, 7, 0, 1'b1, 1'b0);
    run_instr(T_MV, 9, 0, 0, 1'b0, 1'b0);
    run_instr(T_ADD, 2, 8, 0, 1'b0, 1'b0);
    run_instr(T_MVI, 7, 0, 1, 1'b0, 1'b0);
    run_instr(T_BR, 0, 3, 0, 1'b0, 1'b0);
    run_instr(T_AND, 7, 0, 0, 1'b1, 1'b0);

    // Reset in EXEC2 must abort the add and clear Z even though alu_zero=1.
    run_instr(T_ADD, 5, 6, 0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("abort_idle", '0);
    do_start();
    run_instr(T_BZ, 1, 1, 0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int op, rx, ry;
      op = int'($urandom_range(0, 6));
      rx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NREG, 15))
                                       : int'($urandom_range(0, NREG - 1));
      ry = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NREG, 15))
                                       : int'($urandom_range(0, NREG - 1));
      if (op == T_BZ || op == T_BR) rx = int'($urandom_range(0, NREG - 1));
      run_instr(op, rx, ry, int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end

    run_instr(T_HALT, 0, 0, 1, 1'b0, 1'b0);
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start     = 1'($urandom);
      mem_ready = 1'($urandom);
      step("halt_hold", e);
    end
    start = 1'b0; mem_ready = 1'b0;
    rst = 1'b1;
    step("halt_rst", e);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("post_halt_idle", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
